datapath_rf: RTL



---
 rtl/datapath_rf.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/datapath_rf.sv
// Register-file datapath: PC, IR, accumulator, register file and ALU, driven
// by a two-state command FSM. Single-cycle commands finish on the accept
// edge; FETCH/LOAD_REG/STORE_REG hold a memory request until mem_ack.
module datapath_rf #(
  parameter int INST_SIZE     = 6,
  parameter int REG_ADDR_SIZE = 4,
  parameter int MEM_ADDR_SIZE = 6,
  parameter int WORD_SIZE     = INST_SIZE + REG_ADDR_SIZE + MEM_ADDR_SIZE,
  parameter int R0_ZERO       = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd,
  input  logic [2:0]               alu_operation,
  output logic                     done,
  output logic [INST_SIZE-1:0]     opcode,
  output logic                     alu_zero,
  output logic                     alu_overflow,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [MEM_ADDR_SIZE-1:0] mem_address_bus,
  output logic [WORD_SIZE-1:0]     mem_data_out,
  input  logic [WORD_SIZE-1:0]     mem_data_in,
  input  logic                     mem_ack,
  output logic [MEM_ADDR_SIZE-1:0] pc_out
);
  localparam int NUM_REGS = 2**REG_ADDR_SIZE;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MEM  = 1'b1;

  localparam logic [2:0] C_FETCH  = 3'd0;
  localparam logic [2:0] C_LOAD   = 3'd1;
  localparam logic [2:0] C_STORE  = 3'd2;
  localparam logic [2:0] C_ALU    = 3'd3;
  localparam logic [2:0] C_MOV    = 3'd4;
  localparam logic [2:0] C_LIMM   = 3'd5;
  localparam logic [2:0] C_JUMP   = 3'd6;
  localparam logic [2:0] C_BRZ    = 3'd7;

  logic [0:0]               state;
  logic [2:0]               cmd_q;
  logic [MEM_ADDR_SIZE-1:0] pc;
  logic [WORD_SIZE-1:0]     ir;
  logic [WORD_SIZE-1:0]     acc;
  logic [WORD_SIZE-1:0]     rf [NUM_REGS];

  logic [MEM_ADDR_SIZE-1:0] op1;
  logic [REG_ADDR_SIZE-1:0] rsel;
  logic                     r0_hit;
  logic [WORD_SIZE-1:0]     rval;
  logic [WORD_SIZE-1:0]     sum, diff, alu_res;
  logic                     alu_ovf;

  assign op1       = ir[WORD_SIZE-INST_SIZE-1 -: MEM_ADDR_SIZE];
  assign rsel      = ir[REG_ADDR_SIZE-1:0];
  assign opcode    = ir[WORD_SIZE-1 -: INST_SIZE];
  assign pc_out    = pc;
  assign cmd_ready = (state == S_IDLE);

  // R0 is hardwired to zero when R0_ZERO is set: reads return 0, writes drop
  assign r0_hit = (R0_ZERO != 0) && (rsel == '0);
  assign rval   = r0_hit ? '0 : rf[rsel];

  assign sum  = acc + rval;
  assign diff = acc - rval;

  // ALU result and signed-overflow for the op offered with the command
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_operation)
      3'd0: begin
        alu_res = sum;
        alu_ovf = (acc[WORD_SIZE-1] == rval[WORD_SIZE-1]) &&
                  (sum[WORD_SIZE-1] != acc[WORD_SIZE-1]);
      end
      3'd1: begin
        alu_res = diff;
        alu_ovf = (acc[WORD_SIZE-1] != rval[WORD_SIZE-1]) &&
                  (diff[WORD_SIZE-1] != acc[WORD_SIZE-1]);
      end
      3'd2: alu_res = acc & rval;
      3'd3: alu_res = acc | rval;
      3'd4: alu_res = acc ^ rval;
      3'd5: alu_res = ~acc;
      3'd6: alu_res = {acc[WORD_SIZE-2:0], 1'b0};
      default: alu_res = {1'b0, acc[WORD_SIZE-1:1]};
    endcase
  end

  // Command FSM, architectural state and registered memory interface
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= S_IDLE;
      cmd_q           <= C_FETCH;
      pc              <= '0;
      ir              <= '0;
      acc             <= '0;
      alu_zero        <= 1'b0;
      alu_overflow    <= 1'b0;
      done            <= 1'b0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_address_bus <= '0;
      mem_data_out    <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        if (cmd_valid) begin
          case (cmd)
            C_FETCH, C_LOAD, C_STORE: begin
              state           <= S_MEM;
              cmd_q           <= cmd;
              mem_req         <= 1'b1;
              mem_we          <= (cmd == C_STORE);
              mem_address_bus <= (cmd == C_FETCH) ? pc : op1;
              mem_data_out    <= (cmd == C_STORE) ? rval : '0;
            end
            C_ALU: begin
              acc          <= alu_res;
              alu_zero     <= (alu_res == '0);
              alu_overflow <= alu_ovf;
              done         <= 1'b1;
            end
            C_MOV: begin
              if (!r0_hit) rf[rsel] <= acc;
              done <= 1'b1;
            end
            C_LIMM: begin
              acc  <= WORD_SIZE'(op1);
              done <= 1'b1;
            end
            C_JUMP: begin
              pc   <= op1;
              done <= 1'b1;
            end
            default: begin
              if (alu_zero) pc <= op1;
              done <= 1'b1;
            end
          endcase
        end
      end else if (mem_ack) begin
        // IR is untouched while in MEM, so rsel still names the target register
        if (cmd_q == C_FETCH) begin
          ir <= mem_data_in;
          pc <= pc + MEM_ADDR_SIZE'(1);
        end else if (cmd_q == C_LOAD && !r0_hit) begin
          rf[rsel] <= mem_data_in;
        end
        state        <= S_IDLE;
        mem_req      <= 1'b0;
        mem_we       <= 1'b0;
        mem_data_out <= '0;
        done         <= 1'b1;
      end
    end
  end
endmodule
